clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time controller for an even clock divider. Produces clk_out = clk_in/(2*half), where half is a
//  half-period length in clk_in cycles. Starts and stops on en, with no runt pulses.
//  Accepts new ratios over a valid/ready handshake and applies them only on a period boundary.
//  Sits between the config/register logic and every consumer of a divided clock or strobe.
// PARAMETERS
//  CW        8   width of half-period count and counter
//  DEF_HALF  1   half-period loaded at reset (divide-by-2)
// PORTS
//  clk_in       in   1    source clock
//  rst          in   1    asynchronous, active-low reset
//  en           in   1    run request (level)
//  cfg_valid    in   1    new ratio offered
//  cfg_half     in   CW   new half-period, in clk_in cycles
//  cfg_ready    out  1    pending slot empty; handshake completes on cfg_valid&cfg_ready
//  clk_out      out  1    divided clock (registered)
//  period_done  out  1    1-cycle pulse on each clk_out 1->0 toggle
//  busy         out  1    state != IDLE
//  active_half  out  CW   half-period currently in use
// BEHAVIOUR
//  Reset values: clk_out=0, period_done=0, busy=0, cfg_ready=1, active_half=DEF_HALF, cnt=0, pending empty.
//  FSM IDLE/RUN/DRAIN:
//   - IDLE: clk_out=0, cnt=0.
//   - IDLE->RUN on en=1. The first toggle 0->1 happens half cycles after the en-sampling edge.
//   - RUN: cnt increments each cycle. At cnt==active_half-1: cnt<=0 and clk_out toggles.
//   - RUN->DRAIN on en=0 while clk_out was not toggling 1->0 on that edge.
//   - DRAIN: counting continues; on the next 1->0 toggle go to IDLE. No runt pulse or truncated high phase.
//   - DRAIN->RUN if en=1 again; counting is not disturbed.
//   - en falling on the same edge as a 1->0 toggle goes straight to IDLE.
//  Boundary = edge on which clk_out toggles 1->0. period_done pulses on every boundary, including the final DRAIN one.
//  Config handshake (one-entry pending register):
//   - An accepted cfg sets pending full and drives cfg_ready=0 the next cycle.
//   - In RUN/DRAIN: pending is copied to active_half at the next boundary, then cnt restarts at 0.
//     cfg_ready returns to 1 the cycle after that boundary.
//   - In IDLE: pending is applied on the edge after acceptance.
//   - Accept on the same edge as a boundary: the value goes to pending and is applied at the following
//     boundary, not the current one.
//   - en rise in the same cycle as an IDLE apply: RUN starts with the new value.
//  cfg_half==0 is illegal (see CONFIGURATION). A value of 1 gives divide-by-2.
//  Counter compare is at CW width; no overflow, since cnt < active_half always.
//  Reset mid-operation: all state returns to reset values immediately, and pending is discarded.
// CONFIGURATION
//  CLKDIV_CFG_CHECK_EN defined:
//   - Adds output cfg_err (1 bit, reset 0).
//   - An offer with cfg_half==0 is still handshaken but discarded, and sets cfg_err sticky until reset.
//   - active_half is unchanged.
//  Undefined: cfg_half==0 is clamped to 1 on acceptance; there is no cfg_err port.
// STRUCTURE
//  Shared package clkdiv_pkg:
//   - state enum (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2)
//   - DEF_CW=8 and the HALF_MIN=1 constant.
//  Sub-module clk_div_core: cnt, compare, clk_out toggle and boundary flag, with inputs run and load_half.
//  The FSM, pending register and handshake stay in clk_div_ctrl.
// TESTING
//  1. Reset, en=1, no cfg -> clk_out period 2 clk_in cycles, period_done every 2 cycles, busy=1.
//  2. RUN with half=2; offer cfg_half=4 mid-high-phase:
//     -> cfg_ready=0 the next cycle; the last old period is 4 cycles, new periods 8 cycles;
//        cfg_ready=1 the cycle after the boundary.
//  3. half=3; drop en one cycle after a 0->1 toggle:
//     -> high phase still lasts 3 cycles, then IDLE with clk_out=0; busy falls on that boundary.
//  4. DRAIN then re-raise en before the boundary -> no gap, period stays 6 cycles, state RUN.
//  5. Offer on the exact boundary edge, plus a second offer while pending is full:
//     -> first value applied one period later; second held off (cfg_ready=0) until then.
//  6. cfg_half=0 -> with CLKDIV_CFG_CHECK_EN: cfg_err=1 and active_half unchanged;
//     without it: active_half=1. Assert rst low mid-period -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the run-time even clock divider: FSM state
// encoding, default counter width and the smallest legal half-period.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_CW   = 8;
    localparam int HALF_MIN = 1;

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: half-period counter, compare, clk_out toggle and the
// boundary flag (the edge on which clk_out falls). run=0 holds everything
// at zero; load_half restarts the count when a new half-period is taken.
module clk_div_core
    import clkdiv_pkg::*;
#(
    parameter int CW = DEF_CW
)(
    input  logic          clk_in,
    input  logic          rst,
    input  logic          run,
    input  logic          load_half,
    input  logic [CW-1:0] half,
    output logic          clk_out,
    output logic          boundary,
    output logic          period_done
);

    logic [CW-1:0] cnt;
    logic          tick;

    // cnt never exceeds half-1, so the compare needs no overflow guard
    assign tick     = (cnt == half - CW'(1));
    assign boundary = run & tick & clk_out;

    // Count half-periods, toggle clk_out on terminal count, flag each falling toggle
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            period_done <= boundary;
            if (!run) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (tick) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else if (load_half) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for an even clock divider (clk_out = clk_in/(2*half)).
// Owns the IDLE/RUN/DRAIN FSM, the one-entry pending ratio register and the
// valid/ready handshake; new ratios take effect only on a falling clk_out
// boundary (or on the next edge while idle).
// Optional feature: define CLKDIV_CFG_CHECK_EN to reject cfg_half==0 and
// report it on a sticky cfg_err output; otherwise a zero is clamped to 1.
module clk_div_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int DEF_HALF = 1
)(
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_half,
    output logic          cfg_ready,
    output logic          clk_out,
    output logic          period_done,
    output logic          busy,
    output logic [CW-1:0] active_half
`ifdef CLKDIV_CFG_CHECK_EN
    ,
    output logic          cfg_err
`endif
);

    state_t        state, state_nx;
    logic          pend_full;
    logic [CW-1:0] pend_half;
    logic [CW-1:0] cfg_val;
    logic          accept;
    logic          take;
    logic          boundary;
    logic          apply;
    logic          run;

`ifdef CLKDIV_CFG_CHECK_EN
    // A zero ratio completes the handshake but never reaches the pending slot
    assign take    = accept & (cfg_half != '0);
    assign cfg_val = cfg_half;

    // Sticky error flag for rejected zero ratios
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            cfg_err <= 1'b0;
        else if (accept && (cfg_half == '0))
            cfg_err <= 1'b1;
    end
`else
    function automatic logic [CW-1:0] clamp_half(input logic [CW-1:0] h);
        return (h < CW'(HALF_MIN)) ? CW'(HALF_MIN) : h;
    endfunction

    assign take    = accept;
    assign cfg_val = clamp_half(cfg_half);
`endif

    assign cfg_ready = ~pend_full;
    assign accept    = cfg_valid & cfg_ready;
    assign run       = (state != IDLE);
    assign busy      = run;
    // Idle: apply on the edge after acceptance. Running: only on a falling boundary.
    assign apply     = pend_full & (~run | boundary);

    // FSM state register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state: a stop request waits for the falling boundary so no high phase is cut short
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = boundary ? IDLE : DRAIN;
            DRAIN: begin
                if (en)
                    state_nx = RUN;
                else if (boundary)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pending-slot occupancy and the active half-period
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            pend_full   <= 1'b0;
            active_half <= CW'(DEF_HALF);
        end else begin
            if (take)
                pend_full <= 1'b1;
            else if (apply)
                pend_full <= 1'b0;
            if (apply)
                active_half <= pend_half;
        end
    end

    // Pending ratio value; only meaningful while pend_full is set
    always_ff @(posedge clk_in) begin
        if (take)
            pend_half <= cfg_val;
    end

    clk_div_core #(
        .CW (CW)
    ) u_core (
        .clk_in      (clk_in),
        .rst         (rst),
        .run         (run),
        .load_half   (apply),
        .half        (active_half),
        .clk_out     (clk_out),
        .boundary    (boundary),
        .period_done (period_done)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: table of per-cycle vectors with
// hand-derived expected outputs routed through a scoreboard queue, plus a
// hand-written asynchronous mid-period reset sequence.
module tb_clk_div_ctrl;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_half;
    logic       cfg_ready;
    logic       clk_out;
    logic       period_done;
    logic       busy;
    logic [7:0] active_half;
`ifdef CLKDIV_CFG_CHECK_EN
    logic       cfg_err;
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    clk_div_ctrl #(.CW(8), .DEF_HALF(1)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .clk_out     (clk_out),
        .period_done (period_done),
        .busy        (busy),
        .active_half (active_half)
`ifdef CLKDIV_CFG_CHECK_EN
        ,
        .cfg_err     (cfg_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rb;
        logic       en;
        logic       vld;
        logic [7:0] half;
        logic       co;
        logic       pd;
        logic       b;
        logic       r;
        logic [7:0] ah;
        logic       err;
    } vec_t;

    vec_t tbl [80];
    int   n = 0;
    vec_t sb [$];
    vec_t exp_v;
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rb, input logic e, input logic v, input logic [7:0] h,
                       input logic co, input logic pd, input logic b, input logic r,
                       input logic [7:0] ah, input logic err);
        tbl[n].rb = rb;  tbl[n].en = e;  tbl[n].vld = v; tbl[n].half = h;
        tbl[n].co = co;  tbl[n].pd = pd; tbl[n].b = b;   tbl[n].r = r;
        tbl[n].ah = ah;  tbl[n].err = err;
        n++;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
        #2;
        check("rst_clk_out", -1, clk_out, 0);
        check("rst_period_done", -1, period_done, 0);
        check("rst_busy", -1, busy, 0);
        check("rst_cfg_ready", -1, cfg_ready, 1);
        check("rst_active_half", -1, active_half, 1);
`ifdef CLKDIV_CFG_CHECK_EN
        check("rst_cfg_err", -1, cfg_err, 0);
`endif
        @(negedge clk_in);
        rst = 1'b1;
    endtask

    task automatic step(input logic e, input logic v, input logic [7:0] h);
        en = e; cfg_valid = v; cfg_half = h;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
        #1;

        // T1: default half=1, divide-by-2
        add(1,1,0,0, 0,0,1,1,1,0);
        add(0,1,0,0, 1,0,1,1,1,0);
        add(0,1,0,0, 0,1,1,1,1,0);
        add(0,1,0,0, 1,0,1,1,1,0);
        add(0,1,0,0, 0,1,1,1,1,0);
        add(0,1,0,0, 1,0,1,1,1,0);
        // T2: half=2, offer 4 mid-high-phase
        add(1,0,1,2, 0,0,0,0,1,0);
        add(0,0,0,0, 0,0,0,1,2,0);
        add(0,1,0,0, 0,0,1,1,2,0);
        add(0,1,0,0, 0,0,1,1,2,0);
        add(0,1,0,0, 1,0,1,1,2,0);
        add(0,1,1,4, 1,0,1,0,2,0);
        add(0,1,0,0, 0,1,1,1,4,0);
        add(0,1,0,0, 0,0,1,1,4,0);
        add(0,1,0,0, 0,0,1,1,4,0);
        add(0,1,0,0, 0,0,1,1,4,0);
        add(0,1,0,0, 1,0,1,1,4,0);
        add(0,1,0,0, 1,0,1,1,4,0);
        add(0,1,0,0, 1,0,1,1,4,0);
        add(0,1,0,0, 1,0,1,1,4,0);
        add(0,1,0,0, 0,1,1,1,4,0);
        // T3: half=3, en drops one cycle after the rising toggle
        add(1,0,1,3, 0,0,0,0,1,0);
        add(0,0,0,0, 0,0,0,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 1,0,1,1,3,0);
        add(0,0,0,0, 1,0,1,1,3,0);
        add(0,0,0,0, 1,0,1,1,3,0);
        add(0,0,0,0, 0,1,0,1,3,0);
        add(0,0,0,0, 0,0,0,1,3,0);
        // T4: DRAIN then en re-raised before the boundary
        add(1,0,1,3, 0,0,0,0,1,0);
        add(0,0,0,0, 0,0,0,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 1,0,1,1,3,0);
        add(0,0,0,0, 1,0,1,1,3,0);
        add(0,1,0,0, 1,0,1,1,3,0);
        add(0,1,0,0, 0,1,1,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        add(0,1,0,0, 1,0,1,1,3,0);
        add(0,1,0,0, 1,0,1,1,3,0);
        add(0,1,0,0, 1,0,1,1,3,0);
        add(0,1,0,0, 0,1,1,1,3,0);
        // T5: offer on the boundary edge, second offer held off while pending full
        add(1,1,0,0, 0,0,1,1,1,0);
        add(0,1,0,0, 1,0,1,1,1,0);
        add(0,1,1,2, 0,1,1,0,1,0);
        add(0,1,1,3, 1,0,1,0,1,0);
        add(0,1,1,3, 0,1,1,1,2,0);
        add(0,1,1,3, 0,0,1,0,2,0);
        add(0,1,0,0, 1,0,1,0,2,0);
        add(0,1,0,0, 1,0,1,0,2,0);
        add(0,1,0,0, 0,1,1,1,3,0);
        add(0,1,0,0, 0,0,1,1,3,0);
        // T6: zero ratio, clamped or rejected depending on the build
        add(1,0,1,3, 0,0,0,0,1,0);
        add(0,0,0,0, 0,0,0,1,3,0);
        add(0,0,1,0, 0,0,0,CHK,3,CHK);
        add(0,0,0,0, 0,0,0,1,(CHK ? 8'd3 : 8'd1),CHK);
        add(0,1,0,0, 0,0,1,1,(CHK ? 8'd3 : 8'd1),CHK);
        add(0,1,0,0, ~CHK,0,1,1,(CHK ? 8'd3 : 8'd1),CHK);

        for (int i = 0; i < n; i++) begin
            if (tbl[i].rb) do_reset();
            en = tbl[i].en; cfg_valid = tbl[i].vld; cfg_half = tbl[i].half;
            sb.push_back(tbl[i]);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            check("clk_out", i, clk_out, exp_v.co);
            check("period_done", i, period_done, exp_v.pd);
            check("busy", i, busy, exp_v.b);
            check("cfg_ready", i, cfg_ready, exp_v.r);
            check("active_half", i, active_half, exp_v.ah);
`ifdef CLKDIV_CFG_CHECK_EN
            check("cfg_err", i, cfg_err, exp_v.err);
`endif
        end

        // Asynchronous reset in the middle of a high phase with a ratio pending
        do_reset();
        step(0, 1, 8'd3);
        step(0, 0, 8'd0);
        repeat (4) step(1, 0, 8'd0);
        step(1, 1, 8'd5);
        check("pre_rst_clk_out", 100, clk_out, 1);
        check("pre_rst_cfg_ready", 100, cfg_ready, 0);
        check("pre_rst_active_half", 100, active_half, 3);
        #2 rst = 1'b0;
        #1;
        check("async_rst_clk_out", 101, clk_out, 0);
        check("async_rst_period_done", 101, period_done, 0);
        check("async_rst_busy", 101, busy, 0);
        check("async_rst_cfg_ready", 101, cfg_ready, 1);
        check("async_rst_active_half", 101, active_half, 1);
        @(posedge clk_in);
        #1;
        check("held_rst_busy", 102, busy, 0);
        check("held_rst_clk_out", 102, clk_out, 0);
        @(negedge clk_in);
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        step(0, 0, 8'd0);
        step(0, 0, 8'd0);
        check("discard_cfg_ready", 103, cfg_ready, 1);
        check("discard_active_half", 103, active_half, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
